// File: rtl/pc_fetch_sequencer_if.sv
// ----------------------------------------------------------------------------
// pc_fetch_sequencer_if
//   Groups the fetch sequencer's memory, decode, redirect and control signals.
//
//   Handshake semantics:
//     imem side  : imemReq is held high with a stable imemAddr until the cycle
//                  in which imemAck=1; imemData is valid only in that cycle.
//     decode side: instrValid/instr/instrPc stay stable until the cycle in which
//                  instrValid=1 and instrReady=1 (the transfer cycle).
//
//   Signals (direction seen from the sequencer, modport master):
//     imemReq, imemAddr[N]        out  fetch request / address
//     imemAck, imemData[32]       in   memory completion / instruction word
//     instrValid, instr, instrPc  out  instruction presented to decode
//     instrReady                  in   decode accepts
//     redirectValid, redirectTarget in redirect pulse / new PC
//     halt                        in   stop at next instruction boundary
//     trapMisaligned              out  misaligned redirect pulse
// ----------------------------------------------------------------------------
interface pc_fetch_sequencer_if #(
    parameter int N = 32
) ();
    logic         imemReq;
    logic [N-1:0] imemAddr;
    logic         imemAck;
    logic [31:0]  imemData;
    logic         instrValid;
    logic [31:0]  instr;
    logic [N-1:0] instrPc;
    logic         instrReady;
    logic         redirectValid;
    logic [N-1:0] redirectTarget;
    logic         halt;
    logic         trapMisaligned;

    modport master (
        output imemReq, imemAddr, instrValid, instr, instrPc, trapMisaligned,
        input  imemAck, imemData, instrReady, redirectValid, redirectTarget, halt
    );

    modport slave (
        input  imemReq, imemAddr, instrValid, instr, instrPc, trapMisaligned,
        output imemAck, imemData, instrReady, redirectValid, redirectTarget, halt
    );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// ----------------------------------------------------------------------------
// pc_fetch_sequencer
//   Owns the architectural PC and sequences instruction fetch: issues an imem
//   request, captures the returned word, presents it to decode, then advances
//   the PC by 4 on the decode handshake. Applies execute redirects and stops
//   at instruction boundaries while halt is high.
//
//   Ports:
//     clk          in   rising-edge clock
//     rst_n        in   asynchronous active-low reset
//     bus          master modport of pc_fetch_sequencer_if (see that file)
//     o_dbg_state  out  current FSM state (BOOT=0, REQ=1, ISSUE=2, HALT=3)
//
//   Optional feature macro: PC_MISALIGN_TRAP_EN
//     defined   : a redirect target with [1:0]!=0 loads TRAP_VECTOR and pulses
//                 trapMisaligned for one cycle.
//     undefined : redirect target is word-aligned by clearing [1:0];
//                 trapMisaligned is always 0.
// ----------------------------------------------------------------------------
module pc_fetch_sequencer #(
    parameter int           N            = 32,
    parameter logic [N-1:0] RESET_VECTOR = '0
`ifdef PC_MISALIGN_TRAP_EN
    ,
    parameter logic [N-1:0] TRAP_VECTOR  = N'(32'h0000_0100)
`endif
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pc_fetch_sequencer_if.master    bus,
    output logic [1:0]              o_dbg_state
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_REQ   = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t       r_state;
    logic [N-1:0] r_pc;
    logic [N-1:0] r_addr;       // address of the outstanding request, 0 when idle
    logic         r_req;
    logic         r_valid;
    logic [31:0]  r_instr;
    logic [N-1:0] r_instr_pc;
    logic         r_trap;
    logic         r_kill;       // outstanding request belongs to a squashed path

    logic [N-1:0] w_tgt;        // redirect target after alignment handling
    logic         w_trap_set;
    logic [N-1:0] w_pc_inc;
    logic [N-1:0] w_pc_next;    // pc after an optional redirect this cycle

    always_comb begin
`ifdef PC_MISALIGN_TRAP_EN
        if (bus.redirectTarget[1:0] != 2'b00) begin
            w_tgt = TRAP_VECTOR;
        end else begin
            w_tgt = bus.redirectTarget;
        end
        w_trap_set = bus.redirectValid && (bus.redirectTarget[1:0] != 2'b00);
`else
        w_tgt      = bus.redirectTarget & ~N'(3);
        w_trap_set = 1'b0;
`endif
        w_pc_inc  = r_pc + N'(4);
        w_pc_next = bus.redirectValid ? w_tgt : r_pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_VECTOR;
            r_addr     <= '0;
            r_req      <= 1'b0;
            r_valid    <= 1'b0;
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_trap     <= 1'b0;
            r_kill     <= 1'b0;
        end else begin
            r_trap <= w_trap_set;
            case (r_state)
                ST_BOOT: begin
                    r_pc <= w_pc_next;
                    if (bus.halt) begin
                        r_state <= ST_HALT;
                    end else begin
                        r_state <= ST_REQ;
                        r_req   <= 1'b1;
                        r_addr  <= w_pc_next;
                    end
                end
                ST_REQ: begin
                    if (bus.imemAck) begin
                        if (bus.redirectValid || r_kill) begin
                            // Returned word is from a squashed path: drop it and
                            // immediately request from the (possibly new) pc.
                            r_kill <= 1'b0;
                            r_pc   <= w_pc_next;
                            r_addr <= w_pc_next;
                        end else begin
                            r_instr    <= bus.imemData;
                            r_instr_pc <= r_pc;
                            r_valid    <= 1'b1;
                            r_req      <= 1'b0;
                            r_addr     <= '0;
                            r_state    <= ST_ISSUE;
                        end
                    end else if (bus.redirectValid) begin
                        // Memory cannot take the request back: keep imemAddr,
                        // remember to discard its data, retarget the pc.
                        r_kill <= 1'b1;
                        r_pc   <= w_tgt;
                    end
                end
                ST_ISSUE: begin
                    if (bus.redirectValid) begin
                        // Redirect wins over a simultaneous decode accept.
                        r_pc    <= w_tgt;
                        r_valid <= 1'b0;
                        r_state <= ST_REQ;
                        r_req   <= 1'b1;
                        r_addr  <= w_tgt;
                    end else if (bus.instrReady) begin
                        r_pc    <= w_pc_inc;
                        r_valid <= 1'b0;
                        if (bus.halt) begin
                            r_state <= ST_HALT;
                        end else begin
                            r_state <= ST_REQ;
                            r_req   <= 1'b1;
                            r_addr  <= w_pc_inc;
                        end
                    end
                end
                ST_HALT: begin
                    r_pc <= w_pc_next;
                    if (!bus.halt) begin
                        r_state <= ST_REQ;
                        r_req   <= 1'b1;
                        r_addr  <= w_pc_next;
                    end
                end
                default: begin
                    r_state <= ST_BOOT;
                end
            endcase
        end
    end

    assign bus.imemReq        = r_req;
    assign bus.imemAddr       = r_addr;
    assign bus.instrValid     = r_valid;
    assign bus.instr          = r_instr;
    assign bus.instrPc        = r_instr_pc;
    assign bus.trapMisaligned = r_trap;
    assign o_dbg_state        = r_state;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pc_fetch_sequencer
//   Directed sequences and a redirect vector table, followed by a randomized
//   run scored against a program-order model: delivered instructions must
//   follow pc, pc+4, ... restarting at each redirect target, with the word the
//   memory returns for that address.
// ----------------------------------------------------------------------------
module tb_pc_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic [1:0]  dbg_state;
    int          total;
    int          bad;
    int          mem_delay;     // <0: random 0..3 wait cycles per request
    int          wait_left;
    int          hs_count;
    bit          sb_en;
    logic [31:0] exp_q[$];

    pc_fetch_sequencer_if #(.N(32)) bif ();

    pc_fetch_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bif.master),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0050_0093 + (a << 8);
    endfunction

    function automatic logic [31:0] model_tgt(input logic [31:0] t);
`ifdef PC_MISALIGN_TRAP_EN
        return (t % 4 != 0) ? 32'h0000_0100 : t;
`else
        return t - (t % 4);
`endif
    endfunction

    function automatic int pick_delay();
        return (mem_delay < 0) ? int'($urandom_range(0, 3)) : mem_delay;
    endfunction

    // ---------------- memory model ----------------
    always @(posedge clk) begin
        #1;
        if (!rst_n || !bif.imemReq) begin
            bif.imemAck = 1'b0;
            wait_left   = pick_delay();
        end else if (wait_left == 0) begin
            bif.imemAck  = 1'b1;
            bif.imemData = mem_word(bif.imemAddr);
            wait_left    = pick_delay();
        end else begin
            bif.imemAck = 1'b0;
            wait_left--;
        end
    end

    // ---------------- scoreboard ----------------
    logic        p_req, p_ack, p_valid, p_ready, p_redir;
    logic [31:0] p_addr, p_tgt, p_instr, p_ipc;

    always @(negedge clk) begin
        if (sb_en) begin
            logic exp_trap;
            logic [31:0] e;
`ifdef PC_MISALIGN_TRAP_EN
            exp_trap = p_redir && (p_tgt % 4 != 0);
`else
            exp_trap = 1'b0;
`endif
            chk("rnd_trap", 32'(bif.trapMisaligned), 32'(exp_trap));
            if (p_req && !p_ack && bif.imemReq) chk("rnd_addr_hold", bif.imemAddr, p_addr);
            if (!bif.imemReq) chk("rnd_addr_idle", bif.imemAddr, 32'h0);
            if (p_valid && !p_ready && !p_redir) begin
                chk("rnd_valid_hold", 32'(bif.instrValid), 32'h1);
                chk("rnd_pc_hold", bif.instrPc, p_ipc);
                chk("rnd_instr_hold", bif.instr, p_instr);
            end
            if (bif.instrValid && bif.instrReady && !bif.redirectValid) begin
                e = exp_q.pop_front();
                chk("rnd_pc_seq", bif.instrPc, e);
                chk("rnd_data", bif.instr, mem_word(e));
                exp_q.push_back(e + 32'd4);
                hs_count++;
            end
            if (bif.redirectValid) begin
                exp_q.delete();
                exp_q.push_back(model_tgt(bif.redirectTarget));
            end
        end
        p_req   = bif.imemReq;
        p_ack   = bif.imemAck;
        p_addr  = bif.imemAddr;
        p_valid = bif.instrValid;
        p_ready = bif.instrReady;
        p_redir = bif.redirectValid;
        p_tgt   = bif.redirectTarget;
        p_instr = bif.instr;
        p_ipc   = bif.instrPc;
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_n              = 1'b0;
        bif.instrReady     = 1'b0;
        bif.redirectValid  = 1'b0;
        bif.redirectTarget = 32'h0;
        bif.halt           = 1'b0;
        repeat (3) cyc();
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (bif.instrValid) break;
            cyc();
        end
        if (!bif.instrValid) chk("wait_valid_timeout", 32'h0, 32'h1);
    endtask

    typedef struct {
        logic [31:0] tgt;
        logic        rdy;
        logic [31:0] exp_addr;
        logic        exp_trap;
    } rd_vec_t;

    rd_vec_t vecs[5];

    initial begin
        total     = 0;
        bad       = 0;
        hs_count  = 0;
        sb_en     = 1'b0;
        mem_delay = 0;
        rst_n     = 1'b0;

        vecs[0] = '{32'h0000_0040, 1'b1, 32'h0000_0040, 1'b0};
`ifdef PC_MISALIGN_TRAP_EN
        vecs[1] = '{32'h0000_0042, 1'b1, 32'h0000_0100, 1'b1};
        vecs[3] = '{32'h0000_0083, 1'b0, 32'h0000_0100, 1'b1};
`else
        vecs[1] = '{32'h0000_0042, 1'b1, 32'h0000_0040, 1'b0};
        vecs[3] = '{32'h0000_0083, 1'b0, 32'h0000_0080, 1'b0};
`endif
        vecs[2] = '{32'h0000_1000, 1'b0, 32'h0000_1000, 1'b0};
        vecs[4] = '{32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC, 1'b0};

        // ---- reset state and boot sequence ----
        cyc();
        chk("rst_req", 32'(bif.imemReq), 32'h0);
        chk("rst_addr", bif.imemAddr, 32'h0);
        chk("rst_valid", 32'(bif.instrValid), 32'h0);
        chk("rst_instr", bif.instr, 32'h0);
        chk("rst_ipc", bif.instrPc, 32'h0);
        chk("rst_trap", 32'(bif.trapMisaligned), 32'h0);
        mem_delay = 0;
        do_reset();
        bif.instrReady = 1'b1;
        cyc();
        for (int k = 0; k < 3; k++) begin
            chk("boot_req", 32'(bif.imemReq), 32'h1);
            chk("boot_addr", bif.imemAddr, 32'(4 * k));
            cyc();
            chk("boot_valid", 32'(bif.instrValid), 32'h1);
            chk("boot_ipc", bif.instrPc, 32'(4 * k));
            chk("boot_instr", bif.instr, mem_word(32'(4 * k)));
            chk("boot_req_low", 32'(bif.imemReq), 32'h0);
            cyc();
        end

        // ---- backpressure ----
        do_reset();
        cyc();
        cyc();
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("bp_valid", 32'(bif.instrValid), 32'h1);
            chk("bp_instr", bif.instr, 32'h0050_0093);
            chk("bp_ipc", bif.instrPc, 32'h0);
            chk("bp_no_req", 32'(bif.imemReq), 32'h0);
        end
        bif.instrReady = 1'b1;
        cyc();
        bif.instrReady = 1'b0;
        chk("bp_valid_drop", 32'(bif.instrValid), 32'h0);
        chk("bp_next_addr", bif.imemAddr, 32'h4);

        // ---- redirect vectors in ISSUE ----
        for (int v = 0; v < 5; v++) begin
            wait_valid(20);
            bif.instrReady     = vecs[v].rdy;
            bif.redirectValid  = 1'b1;
            bif.redirectTarget = vecs[v].tgt;
            cyc();
            bif.redirectValid = 1'b0;
            bif.instrReady    = 1'b0;
            chk("rv_valid_drop", 32'(bif.instrValid), 32'h0);
            chk("rv_req", 32'(bif.imemReq), 32'h1);
            chk("rv_addr", bif.imemAddr, vecs[v].exp_addr);
            chk("rv_trap", 32'(bif.trapMisaligned), 32'(vecs[v].exp_trap));
            cyc();
            chk("rv_trap_clear", 32'(bif.trapMisaligned), 32'h0);
            chk("rv_ipc", bif.instrPc, vecs[v].exp_addr);
        end

        // ---- pc wrap: 0xFFFFFFFC -> 0 ----
        bif.instrReady = 1'b1;
        cyc();
        bif.instrReady = 1'b0;
        chk("wrap_addr", bif.imemAddr, 32'h0);
        cyc();
        chk("wrap_ipc", bif.instrPc, 32'h0);

        // ---- redirect while a slow request is outstanding ----
        mem_delay = 3;
        cyc();
        bif.instrReady = 1'b1;
        cyc();
        bif.instrReady     = 1'b0;
        bif.redirectValid  = 1'b1;
        bif.redirectTarget = 32'h0000_0080;
        cyc();
        bif.redirectValid = 1'b0;
        mem_delay = 0;
        for (int i = 0; i < 3; i++) begin
            chk("kill_addr_hold", bif.imemAddr, 32'h4);
            chk("kill_req", 32'(bif.imemReq), 32'h1);
            chk("kill_no_valid", 32'(bif.instrValid), 32'h0);
            cyc();
        end
        chk("kill_reissue", bif.imemAddr, 32'h80);
        chk("kill_no_valid2", 32'(bif.instrValid), 32'h0);
        cyc();
        chk("kill_valid", 32'(bif.instrValid), 32'h1);
        chk("kill_ipc", bif.instrPc, 32'h80);
        chk("kill_instr", bif.instr, mem_word(32'h80));

        // ---- halt at boundary ----
        bif.halt       = 1'b1;
        bif.instrReady = 1'b1;
        cyc();
        bif.instrReady = 1'b0;
        chk("halt_valid", 32'(bif.instrValid), 32'h0);
        chk("halt_req", 32'(bif.imemReq), 32'h0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("halt_idle", 32'(bif.imemReq), 32'h0);
        end
        bif.halt = 1'b0;
        cyc();
        chk("resume_req", 32'(bif.imemReq), 32'h1);
        chk("resume_addr", bif.imemAddr, 32'h84);

        // ---- randomized run against the program-order model ----
        mem_delay = -1;
        do_reset();
        exp_q.delete();
        exp_q.push_back(32'h0);
        sb_en = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            bif.instrReady    = ($urandom_range(0, 9) < 7);
            bif.redirectValid = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 3) == 0)
                bif.redirectTarget = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else
                bif.redirectTarget = $urandom;
            if ($urandom_range(0, 49) == 0) bif.halt = ~bif.halt;
            cyc();
        end
        bif.redirectValid = 1'b0;
        bif.halt          = 1'b0;
        bif.instrReady    = 1'b1;
        cyc();
        sb_en = 1'b0;
        chk("rnd_handshakes", 32'(hs_count > 100), 32'h1);

        // ---- asynchronous reset during a request ----
        bif.instrReady = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bif.imemReq) break;
            cyc();
        end
        chk("pre_reset_req", 32'(bif.imemReq), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_req", 32'(bif.imemReq), 32'h0);
        chk("async_rst_addr", bif.imemAddr, 32'h0);
        cyc();
        rst_n = 1'b1;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
